// File: rtl/mio_bus_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle for mio_bus_arbiter: both master ports, the shared slave port and the grant vector.
interface mio_bus_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        m1_err;

  logic        s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ack;

  logic [1:0]  grant;

  // slave is the arbiter's own view; master is the view of the requesters and the memory.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ready, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ready, m1_err,
    output s_req, s_we, s_addr, s_wdata,
    input  s_rdata, s_ack,
    output grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ready, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready, m1_err,
    input  s_req, s_we, s_addr, s_wdata,
    output s_rdata, s_ack,
    input  grant
  );
endinterface

// File: rtl/mio_bus_arbiter.sv
`timescale 1ns/1ps
// Two-master round-robin arbiter for the shared memory/IO bus. Each request is latched,
// forwarded to the slave, and completed with a one-cycle ready pulse; a watchdog aborts stuck accesses.
module mio_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  mio_bus_arbiter_if.slave bus
);
  localparam int unsigned WDW = (TIMEOUT > 31) ? $clog2(TIMEOUT + 1) : 5;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            s_req_q, s_req_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;
  logic [1:0]      ready_q, ready_d;

  logic            pick;
  logic            timeout_hit;
  logic            finish;

  // On a tie the master that was not served last wins; otherwise whoever is asking.
  assign pick        = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
  assign timeout_hit = (TIMEOUT != 0) && (wd_q == WDW'(TIMEOUT - 1));
  assign finish      = bus.s_ack || timeout_hit;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    s_req_d = s_req_q;
    grant_d = grant_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          owner_d = pick;
          we_d    = pick ? bus.m1_we    : bus.m0_we;
          addr_d  = pick ? bus.m1_addr  : bus.m0_addr;
          wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
          wd_d    = '0;
          s_req_d = 1'b1;
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wd_q != '1) wd_d = wd_q + WDW'(1);
        // An ack on the expiry edge still counts as a clean completion.
        if (finish) begin
          rdata_d[owner_q] = bus.s_ack ? bus.s_rdata : ERR_DATA;
          err_d[owner_q]   = ~bus.s_ack;
          ready_d[owner_q] = 1'b1;
          last_d           = owner_q;
          s_req_d          = 1'b0;
          state_d          = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        s_req_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      s_req_q <= 1'b0;
      grant_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      s_req_q <= s_req_d;
      grant_q <= grant_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign bus.s_req    = s_req_q;
  assign bus.s_we     = s_req_q & we_q;
  assign bus.s_addr   = s_req_q ? addr_q  : '0;
  assign bus.s_wdata  = s_req_q ? wdata_q : '0;
  assign bus.grant    = grant_q;
  assign bus.m0_rdata = rdata_q[0];
  assign bus.m0_err   = err_q[0];
  assign bus.m0_ready = ready_q[0];
  assign bus.m1_rdata = rdata_q[1];
  assign bus.m1_err   = err_q[1];
  assign bus.m1_ready = ready_q[1];
endmodule

// File: tb/tb_mio_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for mio_bus_arbiter: directed scenarios with literal expectations plus a long random
// run checked every cycle against a transaction-level model of the arbiter.
module tb_mio_bus_arbiter;
  localparam int unsigned  MTIMEOUT = 16;
  localparam logic [31:0]  MERR     = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  bit   done_seen [2];

  mio_bus_arbiter_if bus ();
  mio_bus_arbiter_if bus4 ();

  mio_bus_arbiter #(.TIMEOUT(MTIMEOUT), .ERR_DATA(MERR)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mio_bus_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: one in-flight access at a time, its age in slave cycles,
  // and whether it has already finished (its ready cycle).
  bit          m_busy, m_fin, m_own, m_last;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_age;
  logic [31:0] m_rdata [2];
  bit          m_err [2];

  task automatic model_reset();
    m_busy = 0; m_fin = 0; m_own = 0; m_last = 1;
    m_we = 0; m_addr = '0; m_wdata = '0; m_age = 0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_err[0] = 0; m_err[1] = 0;
  endtask

  task automatic model_finish(input logic [31:0] data, input bit e);
    m_rdata[m_own] = data;
    m_err[m_own]   = e;
    m_last         = m_own;
    m_fin          = 1;
  endtask

  task automatic model_step();
    int requesters;
    requesters = int'(bus.m0_req) + int'(bus.m1_req);
    if (!m_busy) begin
      if (requesters > 0) begin
        if (requesters == 2) m_own = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else                 m_own = bus.m1_req;
        m_we    = m_own ? bus.m1_we    : bus.m0_we;
        m_addr  = m_own ? bus.m1_addr  : bus.m0_addr;
        m_wdata = m_own ? bus.m1_wdata : bus.m0_wdata;
        m_busy  = 1; m_fin = 0; m_age = 0;
      end
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0;
    end else begin
      m_age++;
      if (bus.s_ack)                              model_finish(bus.s_rdata, 0);
      else if (MTIMEOUT > 0 && m_age == MTIMEOUT) model_finish(MERR, 1);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compareAll();
    bit          sreq;
    logic [1:0]  g;
    sreq = m_busy && !m_fin;
    g    = !m_busy ? 2'b00 : (m_own ? 2'b10 : 2'b01);
    checkOutput("s_req",    32'(bus.s_req),    32'(sreq));
    checkOutput("s_we",     32'(bus.s_we),     32'(sreq && m_we));
    checkOutput("s_addr",   bus.s_addr,        sreq ? m_addr  : 32'h0);
    checkOutput("s_wdata",  bus.s_wdata,       sreq ? m_wdata : 32'h0);
    checkOutput("grant",    32'(bus.grant),    32'(g));
    checkOutput("m0_ready", 32'(bus.m0_ready), 32'(m_busy && m_fin && !m_own));
    checkOutput("m1_ready", 32'(bus.m1_ready), 32'(m_busy && m_fin && m_own));
    checkOutput("m0_err",   32'(bus.m0_err),   32'(m_err[0]));
    checkOutput("m1_err",   32'(bus.m1_err),   32'(m_err[1]));
    checkOutput("m0_rdata", bus.m0_rdata,      m_rdata[0]);
    checkOutput("m1_rdata", bus.m1_rdata,      m_rdata[1]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) compareAll();
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic newReq(input int i);
    if (i == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = 1'($urandom_range(0, 1));
      bus.m0_addr = $urandom; bus.m0_wdata = $urandom;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = 1'($urandom_range(0, 1));
      bus.m1_addr = $urandom; bus.m1_wdata = $urandom;
    end
  endtask

  // One random cycle: masters hold req until their ready, then drop or re-request.
  task automatic applyStimulus(input int ack_pct);
    for (int i = 0; i < 2; i++) begin
      logic rq, rd;
      rq = (i == 0) ? bus.m0_req   : bus.m1_req;
      rd = (i == 0) ? bus.m0_ready : bus.m1_ready;
      if (done_seen[i]) begin
        done_seen[i] = 0;
        if ($urandom_range(0, 2) == 0) newReq(i);
        else if (i == 0) bus.m0_req = 1'b0;
        else             bus.m1_req = 1'b0;
      end else if (!rq) begin
        if ($urandom_range(0, 3) == 0) newReq(i);
      end else if ($urandom_range(0, 1) == 0) begin
        if (i == 0) begin bus.m0_addr = $urandom; bus.m0_wdata = $urandom; end
        else        begin bus.m1_addr = $urandom; bus.m1_wdata = $urandom; end
      end
      if (rd) done_seen[i] = 1;
    end
    bus.s_ack   = ($urandom_range(0, 99) < ack_pct);
    bus.s_rdata = $urandom;
  endtask

  task automatic quiesce();
    step();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_ack = 1'b1;
    repeat (5) step();
    bus.s_ack = 1'b0;
    step();
  endtask

  initial begin
    logic [1:0] order [4];
    logic [1:0] exp_order [4];
    logic [1:0] prev;
    int         n;
    int         pct_tab [3];

    {bus.m0_req, bus.m0_we, bus.m1_req, bus.m1_we, bus.s_ack} = '0;
    bus.m0_addr = '0; bus.m0_wdata = '0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.s_rdata = '0;
    {bus4.m0_req, bus4.m0_we, bus4.m1_req, bus4.m1_we, bus4.s_ack} = '0;
    bus4.m0_addr = '0; bus4.m0_wdata = '0; bus4.m1_addr = '0; bus4.m1_wdata = '0; bus4.s_rdata = '0;
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    pct_tab[0] = 50; pct_tab[1] = 15; pct_tab[2] = 5;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    sample();
    checkOutput("rst_grant",    32'(bus.grant),    32'h0);
    checkOutput("rst_s_req",    32'(bus.s_req),    32'h0);
    checkOutput("rst_m0_ready", 32'(bus.m0_ready), 32'h0);
    checkOutput("rst_m0_rdata", bus.m0_rdata,      32'h0);

    // Single read from master 0, slave acks on its second s_req cycle.
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0000_0010;
    sample(); checkOutput("rd_c0_s_req", 32'(bus.s_req), 32'h0);
    step();
    sample();
    checkOutput("rd_c1_s_req", 32'(bus.s_req), 32'h1);
    checkOutput("rd_c1_grant", 32'(bus.grant), 32'h1);
    checkOutput("rd_c1_addr",  bus.s_addr,     32'h0000_0010);
    step();
    bus.s_ack = 1'b1; bus.s_rdata = 32'hCAFE_1234;
    sample(); checkOutput("rd_c2_s_req", 32'(bus.s_req), 32'h1);
    step();
    bus.s_ack = 1'b0; bus.s_rdata = '0;
    sample();
    checkOutput("rd_c3_ready", 32'(bus.m0_ready), 32'h1);
    checkOutput("rd_c3_rdata", bus.m0_rdata,      32'hCAFE_1234);
    checkOutput("rd_c3_err",   32'(bus.m0_err),   32'h0);
    checkOutput("rd_c3_grant", 32'(bus.grant),    32'h1);
    checkOutput("rd_c3_s_req", 32'(bus.s_req),    32'h0);
    step();
    bus.m0_req = 1'b0;
    sample();
    checkOutput("rd_c4_ready", 32'(bus.m0_ready), 32'h0);
    checkOutput("rd_c4_grant", 32'(bus.grant),    32'h0);
    checkOutput("rd_c4_hold",  bus.m0_rdata,      32'hCAFE_1234);

    // Fresh reset, then both masters hold requests through repeated completions.
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    step();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h100; bus.m1_req = 1'b1; bus.m1_addr = 32'h200;
    bus.m0_we = 1'b0; bus.m1_we = 1'b0; bus.s_ack = 1'b1;
    prev = 2'b00; n = 0;
    for (int c = 0; c < 15; c++) begin
      sample();
      if (bus.grant != 2'b00 && prev == 2'b00) begin
        if (n < 4) order[n] = bus.grant;
        n++;
      end
      prev = bus.grant;
      step();
    end
    checkOutput("rr_count_ge4", 32'(n >= 4), 32'h1);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("rr_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
    quiesce();

    // Master 1 write with a 5-cycle ack delay while its inputs change mid-access.
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'hFFFF_FE00; bus.m1_wdata = 32'h0000_00AA;
    bus.s_rdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 2) begin bus.m1_addr = $urandom; bus.m1_wdata = $urandom; bus.m1_we = 1'b0; end
      if (k == 5) bus.s_ack = 1'b1;
      sample();
      checkOutput($sformatf("wr_c%0d_s_we", k),    32'(bus.s_we), 32'h1);
      checkOutput($sformatf("wr_c%0d_s_addr", k),  bus.s_addr,    32'hFFFF_FE00);
      checkOutput($sformatf("wr_c%0d_s_wdata", k), bus.s_wdata,   32'h0000_00AA);
    end
    step();
    bus.s_ack = 1'b0;
    sample();
    checkOutput("wr_ready", 32'(bus.m1_ready), 32'h1);
    checkOutput("wr_err",   32'(bus.m1_err),   32'h0);
    checkOutput("wr_rdata", bus.m1_rdata,      32'h5A5A_5A5A);
    step();
    bus.m1_req = 1'b0;
    step();

    // Random traffic with varying slave responsiveness, including watchdog expiries.
    done_seen[0] = 0; done_seen[1] = 0;
    for (int blk = 0; blk < 15; blk++) begin
      for (int c = 0; c < 200; c++) begin
        step();
        applyStimulus(pct_tab[blk % 3]);
      end
    end
    quiesce();

    // Reset in the middle of an access clears everything without a clock edge.
    bus.m0_req = 1'b1; bus.m0_addr = 32'h300; bus.m0_we = 1'b0; bus.s_ack = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_s_req",  32'(bus.s_req),    32'h0);
    checkOutput("mid_rst_grant",  32'(bus.grant),    32'h0);
    checkOutput("mid_rst_s_addr", bus.s_addr,        32'h0);
    checkOutput("mid_rst_ready",  32'(bus.m0_ready), 32'h0);
    checkOutput("mid_rst_rdata0", bus.m0_rdata,      32'h0);
    checkOutput("mid_rst_rdata1", bus.m1_rdata,      32'h0);
    bus.m0_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    bus.m0_req = 1'b1; bus.m0_addr = 32'h400; bus.m1_req = 1'b1; bus.m1_addr = 32'h500;
    step();
    sample();
    checkOutput("post_rst_grant", 32'(bus.grant), 32'h1);
    checkOutput("post_rst_addr",  bus.s_addr,     32'h400);
    quiesce();

    // Watchdog with TIMEOUT=4 on the second instance.
    step();
    bus4.m0_req = 1'b1; bus4.m0_we = 1'b0; bus4.m0_addr = 32'h40;
    for (int k = 1; k <= 4; k++) begin
      step(); sample();
      checkOutput($sformatf("to_c%0d_s_req", k), 32'(bus4.s_req), 32'h1);
    end
    step(); sample();
    checkOutput("to_s_req", 32'(bus4.s_req),    32'h0);
    checkOutput("to_ready", 32'(bus4.m0_ready), 32'h1);
    checkOutput("to_err",   32'(bus4.m0_err),   32'h1);
    checkOutput("to_rdata", bus4.m0_rdata,      32'hDEAD_BEEF);
    step(); bus4.m0_req = 1'b0;
    sample(); checkOutput("to_err_hold", 32'(bus4.m0_err), 32'h1);
    step(); bus4.m0_req = 1'b1; bus4.m0_addr = 32'h44;
    step(); bus4.s_ack = 1'b1; bus4.s_rdata = 32'h1234_5678;
    sample(); checkOutput("after_to_s_req", 32'(bus4.s_req), 32'h1);
    step(); bus4.s_ack = 1'b0;
    sample();
    checkOutput("after_to_ready", 32'(bus4.m0_ready), 32'h1);
    checkOutput("after_to_err",   32'(bus4.m0_err),   32'h0);
    checkOutput("after_to_rdata", bus4.m0_rdata,      32'h1234_5678);
    step(); bus4.m0_req = 1'b0;

    // Ack arriving on the same edge the watchdog expires.
    step(); bus4.m0_req = 1'b1; bus4.m0_addr = 32'h48;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) begin bus4.s_ack = 1'b1; bus4.s_rdata = 32'h0BAD_F00D; end
      sample();
      checkOutput($sformatf("col_c%0d_s_req", k), 32'(bus4.s_req), 32'h1);
    end
    step(); bus4.s_ack = 1'b0;
    sample();
    checkOutput("col_ready", 32'(bus4.m0_ready), 32'h1);
    checkOutput("col_err",   32'(bus4.m0_err),   32'h0);
    checkOutput("col_rdata", bus4.m0_rdata,      32'h0BAD_F00D);
    step(); bus4.m0_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
